// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // The occupancy count needs one extra bit so it can represent DEPTH itself.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, combinational read.
module fifo_ram #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, threshold
// flags, occupancy count and overflow/underflow pulses.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 5,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 24,
  parameter int AE_THRESH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                rd_en,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [level_width(ADDR_WIDTH)-1:0]  level,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = level_width(ADDR_WIDTH);

  if (!(AE_THRESH >= 1 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH &&
        (FWFT == FIFO_MODE_STD || FWFT == FIFO_MODE_FWFT))) begin : g_bad_params
    $error("sync_fifo_fwft: illegal FWFT/threshold parameters");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [LW-1:0]         level_next;
  logic                  wr_acc, rd_acc;
  logic                  out_valid;
  logic                  mem_empty;
  logic                  load, bypass, ram_we, mem_pop;

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  assign full      = (level == LW'(DEPTH));
  assign empty     = (FWFT == FIFO_MODE_FWFT) ? !out_valid : (level == '0);
  // In FWFT mode the output register holds one of the counted words.
  assign mem_empty = (level == {{(LW-1){1'b0}}, out_valid});

  always_comb begin
    wr_acc  = wr_en && !full;
    rd_acc  = rd_en && !empty;
    load    = 1'b0;
    bypass  = 1'b0;
    ram_we  = wr_acc;
    mem_pop = rd_acc;
    if (FWFT == FIFO_MODE_FWFT) begin
      load    = !out_valid || rd_acc;
      bypass  = load && mem_empty && wr_acc;
      ram_we  = wr_acc && !bypass;
      mem_pop = load && !mem_empty;
    end
  end

  always_comb begin
    level_next = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      rd_data      <= '0;
      out_valid    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (ram_we)  wr_ptr <= wr_ptr + 1'b1;
      if (mem_pop) rd_ptr <= rd_ptr + 1'b1;
      level        <= level_next;
      almost_full  <= (level_next >= LW'(AF_THRESH));
      almost_empty <= (level_next <= LW'(AE_THRESH));
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
      if (mem_pop)     rd_data <= ram_rdata;
      else if (bypass) rd_data <= wr_data;
      if (load) out_valid <= !mem_empty || wr_acc;
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Runs a standard-mode and an FWFT-mode FIFO side by side against queue models.
module tb_sync_fifo_fwft;

  localparam int DW = 72;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          empty0, empty1, full0, full1;
  logic          af0, af1, ae0, ae1, ov0, ov1, un0, un1;
  logic [AW:0]   level0, level1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_THRESH(24), .AE_THRESH(4)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .empty(empty0), .full(full0), .almost_full(af0),
    .almost_empty(ae0), .level(level0), .overflow(ov0), .underflow(un0));

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_THRESH(24), .AE_THRESH(4)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .empty(empty1), .full(full1), .almost_full(af1),
    .almost_empty(ae1), .level(level1), .overflow(ov1), .underflow(un1));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: each FIFO is just a queue of held words.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  logic          m_ov0 = 1'b0, m_un0 = 1'b0, m_ov1 = 1'b0, m_un1 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete(); q1.delete();
      m_rd0 = '0; m_rd1 = '0;
      m_ov0 = 1'b0; m_un0 = 1'b0; m_ov1 = 1'b0; m_un1 = 1'b0;
    end else begin
      m_ov0 = wr_en && (q0.size() == DEPTH);
      m_un0 = rd_en && (q0.size() == 0);
      m_ov1 = wr_en && (q1.size() == DEPTH);
      m_un1 = rd_en && (q1.size() == 0);
      if (rd_en && q0.size() != 0) m_rd0 = q0.pop_front();
      if (wr_en && !m_ov0) q0.push_back(wr_data);
      if (rd_en && q1.size() != 0) void'(q1.pop_front());
      if (wr_en && !m_ov1) q1.push_back(wr_data);
      if (q1.size() != 0) m_rd1 = q1[0];
    end
  end

  always @(negedge clk) begin
    chk("std_rd_data", rd_data0, m_rd0);
    chk("std_level", DW'(level0), DW'(q0.size()));
    chk("std_empty", DW'(empty0), DW'(q0.size() == 0));
    chk("std_full", DW'(full0), DW'(q0.size() == DEPTH));
    chk("std_almost_full", DW'(af0), DW'(q0.size() >= 24));
    chk("std_almost_empty", DW'(ae0), DW'(q0.size() <= 4));
    chk("std_overflow", DW'(ov0), DW'(m_ov0));
    chk("std_underflow", DW'(un0), DW'(m_un0));
    chk("fwft_rd_data", rd_data1, m_rd1);
    chk("fwft_level", DW'(level1), DW'(q1.size()));
    chk("fwft_empty", DW'(empty1), DW'(q1.size() == 0));
    chk("fwft_full", DW'(full1), DW'(q1.size() == DEPTH));
    chk("fwft_almost_full", DW'(af1), DW'(q1.size() >= 24));
    chk("fwft_almost_empty", DW'(ae1), DW'(q1.size() <= 4));
    chk("fwft_overflow", DW'(ov1), DW'(m_ov1));
    chk("fwft_underflow", DW'(un1), DW'(m_un1));
  end

  initial begin
    int ov_cnt;
    int pw, pr;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Partial fill, then asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = DW'(8'h55 + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_std_level", DW'(level0), 0);
    chk("arst_std_empty", DW'(empty0), 1);
    chk("arst_std_full", DW'(full0), 0);
    chk("arst_std_ae", DW'(ae0), 1);
    chk("arst_fwft_rd_data", rd_data1, 0);
    chk("arst_fwft_empty", DW'(empty1), 1);
    chk("arst_fwft_level", DW'(level1), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x01..0x20, checking thresholds at each level.
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = DW'(i);
      @(posedge clk); #1;
      chk("fill_level", DW'(level0), DW'(i));
      chk("fill_ae", DW'(ae0), DW'(i <= 4));
      chk("fill_af", DW'(af0), DW'(i >= 24));
    end
    chk("fill_full", DW'(full0), 1);
    chk("fill_fwft_head", rd_data1, 1);

    ov_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = DW'(16'hDEAD);
      @(posedge clk); #1;
      ov_cnt += int'(ov0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("overflow_pulses", DW'(ov_cnt), 3);
    chk("overflow_level", DW'(level0), 32);

    // Drain; data must come back 0x01..0x20 with no 0xDEAD.
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      rd_en = 1'b1;
      @(posedge clk); #1;
      chk("drain_std_data", rd_data0, DW'(i));
      chk("drain_fwft_data", rd_data1, DW'(i < DEPTH ? i + 1 : DEPTH));
      chk("drain_level", DW'(level0), DW'(DEPTH - i));
      chk("drain_ae", DW'(ae0), DW'(DEPTH - i <= 4));
      chk("drain_af", DW'(af0), DW'(DEPTH - i >= 24));
    end
    chk("drain_empty", DW'(empty0), 1);

    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk); #1;
    chk("underflow_pulse", DW'(un0), 1);
    chk("underflow_hold", rd_data0, 32);
    @(negedge clk);
    rd_en = 1'b0;

    // FWFT write-to-visible latency.
    wr_en = 1'b1; wr_data = DW'(8'hAA);
    @(posedge clk); #1;
    chk("fwft_bypass_data", rd_data1, DW'(8'hAA));
    chk("fwft_bypass_empty", DW'(empty1), 0);
    chk("fwft_bypass_level", DW'(level1), 1);
    chk("std_latency_empty", DW'(empty0), 0);

    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = DW'(16'h100 + i);
    end

    // Steady state at 16 words across several pointer wraps.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(16'h110 + k);
      @(posedge clk); #1;
      chk("wrap_std_level", DW'(level0), 16);
      chk("wrap_fwft_level", DW'(level1), 16);
      chk("wrap_std_data", rd_data0, (k == 0) ? DW'(8'hAA) : DW'(16'h100 + k));
      chk("wrap_fwft_data", rd_data1, DW'(16'h100 + k + 1));
    end

    pw = 50; pr = 50;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (c % 500 == 0) begin
        pw = int'($urandom_range(10, 90));
        pr = int'($urandom_range(10, 90));
      end
      wr_en = ($urandom_range(0, 99) < pw);
      rd_en = ($urandom_range(0, 99) < pr);
      wr_data = {$urandom, $urandom, $urandom};
      if (c == 5000) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
